// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl_pkg
// Purpose  : Shared width codes, controller state encodings and IO boundary
//            for the byte-wide memory controller.
// Revision : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

    // Access width codes as presented by the LSB
    localparam logic [1:0] c_WIDTH_BYTE = 2'b00;
    localparam logic [1:0] c_WIDTH_HALF = 2'b01;
    localparam logic [1:0] c_WIDTH_WORD = 2'b11;

    // Controller states
    typedef logic [2:0] state_t;
    localparam state_t c_ST_IDLE   = 3'd0;
    localparam state_t c_ST_LSB_RD = 3'd1;
    localparam state_t c_ST_LSB_WR = 3'd2;
    localparam state_t c_ST_IF_RD  = 3'd3;
    localparam state_t c_ST_DONE   = 3'd4;

    // Addresses at or above this boundary are memory-mapped IO
    localparam logic [31:0] c_HCI_ADDR = 32'h0003_0000;

    // Bytes moved for a width code; the unused code 10 behaves as a word
    function automatic logic [2:0] byte_count(input logic [1:0] width);
        case (width)
            c_WIDTH_BYTE: byte_count = 3'd1;
            c_WIDTH_HALF: byte_count = 3'd2;
            default:      byte_count = 3'd4;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl_if
// Purpose  : LSB request/response and instruction-fetch handshake bundle
//            between the core front-end/LSB (master) and mem_ctrl (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface mem_ctrl_if;

    logic        lsb_req_flag;
    logic [1:0]  lsb_req_width;
    logic        lsb_req_type;
    logic        lsb_req_sext;
    logic [31:0] lsb_req_addr;
    logic [31:0] lsb_req_data;
    logic [31:0] lsb_req_rob_id;
    logic        lsb_done_flag;
    logic        ld_cdb_flag;
    logic [31:0] ld_cdb_rob_id;
    logic [31:0] ld_cdb_val;

    logic        if_req_flag;
    logic [31:0] if_req_addr;
    logic        if_done_flag;
    logic [31:0] if_data;

    modport master (
        output lsb_req_flag, lsb_req_width, lsb_req_type, lsb_req_sext,
               lsb_req_addr, lsb_req_data, lsb_req_rob_id,
               if_req_flag, if_req_addr,
        input  lsb_done_flag, ld_cdb_flag, ld_cdb_rob_id, ld_cdb_val,
               if_done_flag, if_data
    );

    modport slave (
        input  lsb_req_flag, lsb_req_width, lsb_req_type, lsb_req_sext,
               lsb_req_addr, lsb_req_data, lsb_req_rob_id,
               if_req_flag, if_req_addr,
        output lsb_done_flag, ld_cdb_flag, ld_cdb_rob_id, ld_cdb_val,
               if_done_flag, if_data
    );

endinterface
`default_nettype wire

// File: rtl/mem_ctrl_byte_asm.sv
`default_nettype none
// ============================================================================
// Module   : mem_byte_asm
// Purpose  : Drops an incoming byte into its lane of a partially assembled
//            word and applies sign/zero extension for the access width.
// Revision : 1.0 - initial release
// ============================================================================
module mem_byte_asm
    import mem_ctrl_pkg::*;
(
    input  wire logic [31:0] i_word,
    input  wire logic [1:0]  i_lane,
    input  wire logic [7:0]  i_byte,
    input  wire logic [1:0]  i_width,
    input  wire logic        i_sext,
    output logic      [31:0] o_raw,
    output logic      [31:0] o_ext
);

    // Lane insert followed by width-dependent extension
    always_comb begin
        o_raw = i_word;
        o_raw[{i_lane, 3'b000} +: 8] = i_byte;
        case (i_width)
            c_WIDTH_BYTE: o_ext = {{24{i_sext & o_raw[7]}}, o_raw[7:0]};
            c_WIDTH_HALF: o_ext = {{16{i_sext & o_raw[15]}}, o_raw[15:0]};
            default:      o_ext = o_raw;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl
// Purpose  : Byte-serial RAM/IO controller serving LSB loads/stores (priority)
//            and instruction fetch, with load extension and CDB broadcast.
// Revision : 1.0 - initial release
// ============================================================================
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter logic [31:0] HCI_ADDR = c_HCI_ADDR
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        rdy,
    input  wire logic [7:0]  mem_din,
    output logic      [7:0]  mem_dout,
    output logic      [31:0] mem_a,
    output logic             mem_wr,
    input  wire logic        io_buffer_full,
    input  wire logic        jump_wrong,
    mem_ctrl_if.slave        bus
);

    state_t      r_state, w_state_nx;
    logic [2:0]  r_cnt, w_cnt_nx;
    logic [31:0] r_addr, w_addr_nx;
    logic [31:0] r_data, w_data_nx;
    logic [1:0]  r_width, w_width_nx;
    logic        r_sext, w_sext_nx;
    logic [31:0] r_rob_id, w_rob_id_nx;

    logic [7:0]  r_mem_dout, w_mem_dout_nx;
    logic [31:0] r_mem_a, w_mem_a_nx;
    logic        r_mem_wr, w_mem_wr_nx;
    logic        r_if_done, w_if_done_nx;
    logic [31:0] r_if_data, w_if_data_nx;
    logic        r_lsb_done, w_lsb_done_nx;
    logic        r_ld_flag, w_ld_flag_nx;
    logic [31:0] r_ld_rob_id, w_ld_rob_id_nx;
    logic [31:0] r_ld_val, w_ld_val_nx;

    logic [2:0]  w_n;
    logic [1:0]  w_lane;
    logic [31:0] w_asm_raw, w_asm_ext;
    logic        w_throttle_acc, w_throttle_wr;

    // r_cnt counts edges since acceptance, so the byte arriving now is lane r_cnt-2
    assign w_n            = byte_count(r_width);
    assign w_lane         = r_cnt[1:0] - 2'd2;
    assign w_throttle_acc = (bus.lsb_req_addr >= HCI_ADDR) && io_buffer_full;
    assign w_throttle_wr  = (r_addr >= HCI_ADDR) && io_buffer_full;

    mem_byte_asm u_byte_asm (
        .i_word  (r_data),
        .i_lane  (w_lane),
        .i_byte  (mem_din),
        .i_width (r_width),
        .i_sext  (r_sext),
        .o_raw   (w_asm_raw),
        .o_ext   (w_asm_ext)
    );

    // Next-state and registered-output computation; outputs default to idle
    always_comb begin
        w_state_nx     = r_state;
        w_cnt_nx       = r_cnt;
        w_addr_nx      = r_addr;
        w_data_nx      = r_data;
        w_width_nx     = r_width;
        w_sext_nx      = r_sext;
        w_rob_id_nx    = r_rob_id;
        w_mem_dout_nx  = 8'h00;
        w_mem_a_nx     = 32'h0;
        w_mem_wr_nx    = 1'b0;
        w_if_done_nx   = 1'b0;
        w_if_data_nx   = 32'h0;
        w_lsb_done_nx  = 1'b0;
        w_ld_flag_nx   = 1'b0;
        w_ld_rob_id_nx = 32'h0;
        w_ld_val_nx    = 32'h0;
        case (r_state)
            c_ST_IDLE: begin
                if (bus.lsb_req_flag) begin
                    w_addr_nx   = bus.lsb_req_addr;
                    w_width_nx  = bus.lsb_req_width;
                    w_sext_nx   = bus.lsb_req_sext;
                    w_rob_id_nx = bus.lsb_req_rob_id;
                    w_mem_a_nx  = bus.lsb_req_addr;
                    if (bus.lsb_req_type) begin
                        w_state_nx    = c_ST_LSB_WR;
                        w_data_nx     = bus.lsb_req_data;
                        w_mem_dout_nx = bus.lsb_req_data[7:0];
                        w_mem_wr_nx   = !w_throttle_acc;
                        w_cnt_nx      = w_throttle_acc ? 3'd0 : 3'd1;
                    end else begin
                        w_state_nx = c_ST_LSB_RD;
                        w_data_nx  = 32'h0;
                        w_cnt_nx   = 3'd1;
                    end
                end else if (bus.if_req_flag && !jump_wrong) begin
                    w_state_nx = c_ST_IF_RD;
                    w_addr_nx  = bus.if_req_addr;
                    w_width_nx = c_WIDTH_WORD;
                    w_sext_nx  = 1'b0;
                    w_data_nx  = 32'h0;
                    w_mem_a_nx = bus.if_req_addr;
                    w_cnt_nx   = 3'd1;
                end
            end
            c_ST_LSB_RD, c_ST_IF_RD: begin
                if (r_state == c_ST_IF_RD && jump_wrong) begin
                    w_state_nx = c_ST_IDLE;
                    w_cnt_nx   = 3'd0;
                end else begin
                    if (r_cnt < w_n)
                        w_mem_a_nx = r_addr + {29'b0, r_cnt};
                    if (r_cnt >= 3'd2)
                        w_data_nx = w_asm_raw;
                    if (r_cnt == w_n + 3'd1) begin
                        w_state_nx = c_ST_DONE;
                        w_cnt_nx   = 3'd0;
                        if (r_state == c_ST_LSB_RD) begin
                            w_lsb_done_nx  = 1'b1;
                            w_ld_flag_nx   = 1'b1;
                            w_ld_rob_id_nx = r_rob_id;
                            w_ld_val_nx    = w_asm_ext;
                        end else begin
                            w_if_done_nx = 1'b1;
                            w_if_data_nx = w_asm_ext;
                        end
                    end else begin
                        w_cnt_nx = r_cnt + 3'd1;
                    end
                end
            end
            c_ST_LSB_WR: begin
                if (r_cnt == w_n) begin
                    w_state_nx    = c_ST_DONE;
                    w_cnt_nx      = 3'd0;
                    w_lsb_done_nx = 1'b1;
                end else begin
                    // A throttled IO byte keeps its address presented but is not written
                    w_mem_a_nx    = r_addr + {29'b0, r_cnt};
                    w_mem_dout_nx = r_data[{r_cnt[1:0], 3'b000} +: 8];
                    if (!w_throttle_wr) begin
                        w_mem_wr_nx = 1'b1;
                        w_cnt_nx    = r_cnt + 3'd1;
                    end
                end
            end
            c_ST_DONE: begin
                w_state_nx = c_ST_IDLE;
                w_cnt_nx   = 3'd0;
            end
            default: begin
                w_state_nx = c_ST_IDLE;
                w_cnt_nx   = 3'd0;
            end
        endcase
    end

    // State and output registers; rdy low freezes everything
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= 3'd0;
            r_addr      <= 32'h0;
            r_data      <= 32'h0;
            r_width     <= 2'b00;
            r_sext      <= 1'b0;
            r_rob_id    <= 32'h0;
            r_mem_dout  <= 8'h00;
            r_mem_a     <= 32'h0;
            r_mem_wr    <= 1'b0;
            r_if_done   <= 1'b0;
            r_if_data   <= 32'h0;
            r_lsb_done  <= 1'b0;
            r_ld_flag   <= 1'b0;
            r_ld_rob_id <= 32'h0;
            r_ld_val    <= 32'h0;
        end else if (rdy) begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_addr      <= w_addr_nx;
            r_data      <= w_data_nx;
            r_width     <= w_width_nx;
            r_sext      <= w_sext_nx;
            r_rob_id    <= w_rob_id_nx;
            r_mem_dout  <= w_mem_dout_nx;
            r_mem_a     <= w_mem_a_nx;
            r_mem_wr    <= w_mem_wr_nx;
            r_if_done   <= w_if_done_nx;
            r_if_data   <= w_if_data_nx;
            r_lsb_done  <= w_lsb_done_nx;
            r_ld_flag   <= w_ld_flag_nx;
            r_ld_rob_id <= w_ld_rob_id_nx;
            r_ld_val    <= w_ld_val_nx;
        end
    end

    assign mem_dout          = r_mem_dout;
    assign mem_a             = r_mem_a;
    assign mem_wr            = r_mem_wr;
    assign bus.if_done_flag  = r_if_done;
    assign bus.if_data       = r_if_data;
    assign bus.lsb_done_flag = r_lsb_done;
    assign bus.ld_cdb_flag   = r_ld_flag;
    assign bus.ld_cdb_rob_id = r_ld_rob_id;
    assign bus.ld_cdb_val    = r_ld_val;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_ctrl
// Purpose  : Directed self-checking bench for mem_ctrl with a one-cycle
//            latency byte RAM and an IO write sink.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst, rdy, io_buffer_full, jump_wrong;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    mem_ctrl_if bus ();

    mem_ctrl #(.HCI_ADDR(32'h0003_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full),
        .jump_wrong     (jump_wrong),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [0:511];
    logic [7:0] io_last;
    int         io_writes;
    int         n_tests = 0;
    int         n_fail  = 0;

    // RAM model: read data one cycle after the address; IO writes are logged
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 512; i++) ram[i] <= 8'h00;
            ram[9'h000] <= 8'hAA; ram[9'h001] <= 8'hBB;
            ram[9'h002] <= 8'hCC; ram[9'h003] <= 8'hDD;
            ram[9'h008] <= 8'h11; ram[9'h009] <= 8'h22;
            ram[9'h00A] <= 8'h33; ram[9'h00B] <= 8'h44;
            ram[9'h020] <= 8'h80;
            ram[9'h022] <= 8'h01; ram[9'h023] <= 8'h80;
            ram[9'h100] <= 8'h78; ram[9'h101] <= 8'h56;
            ram[9'h102] <= 8'h34; ram[9'h103] <= 8'h12;
            io_writes   <= 0;
            io_last     <= 8'h00;
            mem_din     <= 8'h00;
        end else begin
            mem_din <= ram[mem_a[8:0]];
            if (mem_wr) begin
                if (mem_a >= 32'h0003_0000) begin
                    io_last   <= mem_dout;
                    io_writes <= io_writes + 1;
                end else begin
                    ram[mem_a[8:0]] <= mem_dout;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_lsb(input logic typ, input logic [1:0] width, input logic sext,
                           input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] rob);
        bus.lsb_req_type   = typ;
        bus.lsb_req_width  = width;
        bus.lsb_req_sext   = sext;
        bus.lsb_req_addr   = addr;
        bus.lsb_req_data   = data;
        bus.lsb_req_rob_id = rob;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lsb_cnt, lsb_at, if_at, seen, lat;
        logic [31:0] lsb_val, if_val;

        rst = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0; jump_wrong = 1'b0;
        bus.lsb_req_flag = 1'b0; bus.if_req_flag = 1'b0; bus.if_req_addr = 32'h0;
        set_lsb(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0);
        repeat (3) tick();
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_mem_wr", {31'b0, mem_wr}, 32'h0);
        chk("rst_lsb_done", {31'b0, bus.lsb_done_flag}, 32'h0);
        chk("rst_if_done", {31'b0, bus.if_done_flag}, 32'h0);
        chk("rst_ld_cdb", {31'b0, bus.ld_cdb_flag}, 32'h0);
        rst = 1'b0;
        tick();

        // LW 0x100 -> 0x12345678, done five edges after acceptance
        set_lsb(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 32'd7);
        bus.lsb_req_flag = 1'b1;
        tick(); chk("lw_a0", mem_a, 32'h100);
        bus.lsb_req_flag = 1'b0;
        tick(); chk("lw_a1", mem_a, 32'h101);
        tick(); chk("lw_a2", mem_a, 32'h102);
        tick(); chk("lw_a3", mem_a, 32'h103);
        tick(); chk("lw_not_yet", {31'b0, bus.lsb_done_flag}, 32'h0);
        tick(); chk("lw_done", {31'b0, bus.lsb_done_flag}, 32'h1);
        chk("lw_cdb", {31'b0, bus.ld_cdb_flag}, 32'h1);
        chk("lw_val", bus.ld_cdb_val, 32'h1234_5678);
        chk("lw_rob", bus.ld_cdb_rob_id, 32'd7);
        tick(); chk("lw_pulse", {31'b0, bus.lsb_done_flag}, 32'h0);

        // LB sign-extended at 0x20 (0x80)
        set_lsb(1'b0, 2'b00, 1'b1, 32'h20, 32'h0, 32'd3);
        bus.lsb_req_flag = 1'b1;
        tick(); chk("lb_a0", mem_a, 32'h20);
        bus.lsb_req_flag = 1'b0;
        tick(); chk("lb_t1", {31'b0, bus.lsb_done_flag}, 32'h0);
        tick(); chk("lb_done", {31'b0, bus.lsb_done_flag}, 32'h1);
        chk("lb_val", bus.ld_cdb_val, 32'hFFFF_FF80);
        tick();

        // LBU at 0x20
        set_lsb(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 32'd4);
        bus.lsb_req_flag = 1'b1;
        tick(); bus.lsb_req_flag = 1'b0;
        tick(); tick();
        chk("lbu_done", {31'b0, bus.lsb_done_flag}, 32'h1);
        chk("lbu_val", bus.ld_cdb_val, 32'h0000_0080);
        tick();

        // LH sign-extended at 0x22 (0x8001)
        set_lsb(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 32'd2);
        bus.lsb_req_flag = 1'b1;
        tick(); chk("lh_a0", mem_a, 32'h22);
        bus.lsb_req_flag = 1'b0;
        tick(); chk("lh_a1", mem_a, 32'h23);
        tick(); chk("lh_t2", {31'b0, bus.lsb_done_flag}, 32'h0);
        tick(); chk("lh_done", {31'b0, bus.lsb_done_flag}, 32'h1);
        chk("lh_val", bus.ld_cdb_val, 32'hFFFF_8001);
        tick();

        // SW 0xDEADBEEF to 0x40
        set_lsb(1'b1, 2'b11, 1'b0, 32'h40, 32'hDEAD_BEEF, 32'd5);
        bus.lsb_req_flag = 1'b1;
        tick(); chk("sw_wr0", {31'b0, mem_wr}, 32'h1);
        chk("sw_a0", mem_a, 32'h40); chk("sw_d0", {24'b0, mem_dout}, 32'hEF);
        bus.lsb_req_flag = 1'b0;
        tick(); chk("sw_a1", mem_a, 32'h41); chk("sw_d1", {24'b0, mem_dout}, 32'hBE);
        tick(); chk("sw_a2", mem_a, 32'h42); chk("sw_d2", {24'b0, mem_dout}, 32'hAD);
        tick(); chk("sw_a3", mem_a, 32'h43); chk("sw_d3", {24'b0, mem_dout}, 32'hDE);
        chk("sw_wr3", {31'b0, mem_wr}, 32'h1);
        tick(); chk("sw_done", {31'b0, bus.lsb_done_flag}, 32'h1);
        chk("sw_wr_off", {31'b0, mem_wr}, 32'h0);
        chk("sw_no_cdb", {31'b0, bus.ld_cdb_flag}, 32'h0);
        tick();
        chk("sw_ram", {ram[9'h043], ram[9'h042], ram[9'h041], ram[9'h040]}, 32'hDEAD_BEEF);

        // SB to IO with the write buffer full for three edges
        set_lsb(1'b1, 2'b00, 1'b0, 32'h0003_0000, 32'h0000_005A, 32'd6);
        io_buffer_full = 1'b1;
        bus.lsb_req_flag = 1'b1;
        tick(); chk("io_hold0", {31'b0, mem_wr}, 32'h0);
        bus.lsb_req_flag = 1'b0;
        tick(); chk("io_hold1", {31'b0, mem_wr}, 32'h0);
        tick(); chk("io_hold2", {31'b0, mem_wr}, 32'h0);
        chk("io_no_done", {31'b0, bus.lsb_done_flag}, 32'h0);
        io_buffer_full = 1'b0;
        tick(); chk("io_wr", {31'b0, mem_wr}, 32'h1);
        chk("io_a", mem_a, 32'h0003_0000); chk("io_d", {24'b0, mem_dout}, 32'h5A);
        tick(); chk("io_done", {31'b0, bus.lsb_done_flag}, 32'h1);
        chk("io_wr_off", {31'b0, mem_wr}, 32'h0);
        tick();
        chk("io_count", io_writes, 32'd1);
        chk("io_byte", {24'b0, io_last}, 32'h5A);

        // Simultaneous LBU and fetch; LSB pulses repeat while busy and in DONE
        set_lsb(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 32'd9);
        bus.if_req_addr = 32'h8;
        bus.if_req_flag = 1'b1;
        lsb_cnt = 0; lsb_at = -1; if_at = -1; lsb_val = 32'h0; if_val = 32'h0;
        for (int i = 0; i < 12; i++) begin
            bus.lsb_req_flag = (i <= 3);
            tick();
            if (i == 0) chk("prio_lsb_first", mem_a, 32'h20);
            if (i == 4) chk("prio_fetch_a0", mem_a, 32'h8);
            if (bus.lsb_done_flag) begin
                lsb_cnt++; lsb_at = i; lsb_val = bus.ld_cdb_val;
            end
            if (bus.if_done_flag) begin
                if_at = i; if_val = bus.if_data; bus.if_req_flag = 1'b0;
            end
        end
        bus.if_req_flag = 1'b0;
        chk("prio_lsb_count", lsb_cnt, 32'd1);
        chk("prio_lsb_at", lsb_at, 32'd2);
        chk("prio_lsb_val", lsb_val, 32'h0000_0080);
        chk("prio_if_at", if_at, 32'd9);
        chk("prio_if_data", if_val, 32'h4433_2211);

        // Fetch at 0x0 aborted by jump_wrong at the third edge
        bus.if_req_addr = 32'h0;
        bus.if_req_flag = 1'b1;
        tick(); chk("jw_a0", mem_a, 32'h0);
        tick(); chk("jw_a1", mem_a, 32'h1);
        jump_wrong = 1'b1;
        bus.if_req_flag = 1'b0;
        tick(); chk("jw_abort_a", mem_a, 32'h0);
        chk("jw_abort_done", {31'b0, bus.if_done_flag}, 32'h0);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.if_done_flag) seen++;
        end
        chk("jw_no_done", seen, 32'd0);

        // jump_wrong in IDLE blocks acceptance, then the fetch runs normally
        bus.if_req_addr = 32'h8;
        bus.if_req_flag = 1'b1;
        jump_wrong = 1'b1;
        tick(); chk("jw_idle_block", mem_a, 32'h0);
        jump_wrong = 1'b0;
        tick(); chk("jw2_a0", mem_a, 32'h8);
        lat = -1; if_val = 32'h0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (bus.if_done_flag && lat < 0) begin
                lat = i; if_val = bus.if_data; bus.if_req_flag = 1'b0;
            end
        end
        bus.if_req_flag = 1'b0;
        chk("jw2_latency", lat, 32'd5);
        chk("jw2_data", if_val, 32'h4433_2211);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
